dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Memory-side responder for the pipeline's data-memory port. It receives address, write data, write strobe, access size and signedness from the memory stage.
- Performs the access against an internal word-organised RAM with a configurable number of wait states, and returns load data already lane-aligned and extended.
- Stalls the core through a stall output while the access is in progress.
- Flags misaligned accesses so the core can raise an address-error exception.

Parameters:
- ADDR_WIDTH, 10, word-address bits; RAM depth = 2**ADDR_WIDTH 32-bit words.
- WAIT_STATES, 1, extra cycles a valid access is held before completion (0..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- memenM  input  1  access request (load or store) from the memory stage.
- memwriteM  input  1  1 = store, 0 = load; qualified by memenM.
- sizeM  input  2  00 byte, 01 halfword, 10 word; 11 treated as word.
- unsignedM  input  1  load extension: 1 = zero-extend, 0 = sign-extend.
- aluoutM  input  32  byte address.
- writedataM  input  32  store data, right-justified (byte in [7:0], half in [15:0]).
- readdataM  output  32  load result, lane-extracted and extended.
- stallM  output  1  high while the access is not yet complete.
- adelM  output  1  load address misaligned.
- adesM  output  1  store address misaligned.
- buserrM  output  1  out-of-range address; only when the optional feature is compiled in, otherwise tied 0.

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM to IDLE, wait counter 0.
  - readdataM, adelM, adesM and buserrM all 0.
  - stallM 0.
  - RAM contents are not cleared.
- Misalignment check:
  - halfword misaligned when aluoutM[0]=1.
  - word misaligned when aluoutM[1:0]!=0.
  - byte never misaligned.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - memenM=0: stay in IDLE, stallM=0.
  - memenM=1 and misaligned: adelM (load) or adesM (store) is asserted combinationally in the same cycle. stallM=0, no RAM write, readdataM holds, FSM stays in IDLE.
  - memenM=1 and aligned: stallM=1 combinationally. Go to WAIT if WAIT_STATES>0, otherwise go to DONE. The counter loads WAIT_STATES-1.
- WAIT:
  - stallM=1; counter decrements each cycle.
  - At counter 0, go to DONE.
  - Inputs are required stable, because the core is stalled.
- Edge entering DONE:
  - Store: write the enabled byte lanes only. Byte lane = aluoutM[1:0], halfword lane = aluoutM[1], little-endian (address offset 0 maps to bits [7:0]). Store data is replicated to the selected lane.
  - Load: readdataM is registered with the selected lane, shifted to bit 0 and extended per unsignedM. A word load returns the full word.
  - Store leaves readdataM unchanged.
- DONE:
  - stallM=0 and the core advances.
  - memenM is ignored in this cycle, since it belongs to the request just serviced.
  - Next state is IDLE unconditionally.
- Latency: an aligned request first seen in IDLE in cycle 0 gives stallM=1 for cycles 0..WAIT_STATES. DONE is cycle WAIT_STATES+1; readdataM is valid from that cycle and held until the next load completes.
- Back-to-back accesses: one access per WAIT_STATES+2 cycles.
- Word index: aluoutM[ADDR_WIDTH+1:2]; higher bits are ignored (the RAM aliases).
- Reset mid-access (WAIT or DONE): the access is abandoned. A store not yet written is not written; stallM drops immediately.
- memwriteM, sizeM and unsignedM are ignored when memenM=0.

Optional Feature:
- Macro: DMEM_RANGE_CHECK_EN.
- Defined:
  - Any aligned request with aluoutM[31:ADDR_WIDTH+2]!=0 asserts buserrM combinationally in IDLE for that cycle.
  - No stall, no RAM write, readdataM unchanged, FSM stays in IDLE.
  - Misalignment takes priority: only adelM or adesM fires.
- Not defined: buserrM is constant 0 and upper address bits alias.

Test Plan:
- Reset: hold rst=0 with memenM=1 -> readdataM=0, stallM=0, all error flags 0, FSM IDLE.
- WAIT_STATES=1, word store 0xDEADBEEF to 0x10, then word load 0x10:
  - store gives stallM high for 2 cycles then 1 DONE cycle.
  - load returns readdataM=0xDEADBEEF in its DONE cycle.
- Byte stores 0x80 to 0x21 and 0x7F to 0x22 over word 0x20 pre-written 0x00000000:
  - lb 0x21 -> 0xFFFFFF80; lbu 0x21 -> 0x00000080.
  - lh 0x22 -> 0x0000007F.
  - word load -> 0x007F8000.
- Misaligned accesses:
  - lh at 0x31 -> adelM=1 for 1 cycle, stallM=0.
  - sw at 0x32 -> adesM=1, and a later lw 0x30 shows the old data unchanged.
- Reset mid-access: assert rst=0 during WAIT of a sw 0x12345678 to 0x40 -> stallM=0 at once; a later lw 0x40 returns the prior contents.
- DMEM_RANGE_CHECK_EN, ADDR_WIDTH=10: lw at 0x00001000 -> buserrM=1, stallM=0. Without the macro, the same load returns the word at 0x0.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder with wait states, lane-aligned loads,
// byte-enabled stores and misalignment flags.
// Optional build macro DMEM_RANGE_CHECK_EN: flags out-of-range addresses on
// buserrM instead of letting upper address bits alias into the RAM.
module dmem_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memenM,
    input  logic        memwriteM,
    input  logic [1:0]  sizeM,
    input  logic        unsignedM,
    input  logic [31:0] aluoutM,
    input  logic [31:0] writedataM,
    output logic [31:0] readdataM,
    output logic        stallM,
    output logic        adelM,
    output logic        adesM,
    output logic        buserrM
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_t state, stateNext;
    logic [3:0]  waitCnt;
    logic [31:0] mem [2**ADDR_WIDTH];

    logic [ADDR_WIDTH-1:0] wordIdx;
    logic        misaligned, outOfRange, goReq, enterDone;
    logic [31:0] ramWord, loadVal, storeData;
    logic [3:0]  byteEn;
    logic [7:0]  selByte;
    logic [15:0] selHalf;

    assign wordIdx = aluoutM[ADDR_WIDTH+1:2];
    assign ramWord = mem[wordIdx];

`ifdef DMEM_RANGE_CHECK_EN
    assign outOfRange = |aluoutM[31:ADDR_WIDTH+2];
`else
    // Upper address bits alias; they only feed this sink.
    logic unusedHiBits;
    assign unusedHiBits = ^aluoutM[31:ADDR_WIDTH+2];
    assign outOfRange   = 1'b0;
`endif

    // Alignment check by access size (byte is always aligned)
    always_comb begin
        misaligned = 1'b0;
        case (sizeM)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = aluoutM[0];
            default: misaligned = |aluoutM[1:0];
        endcase
    end

    // A request is accepted only in IDLE, while out of reset, when legal.
    // Reset gating keeps combinational flags quiet while rst is held low.
    assign goReq     = rst && (state == IDLE) && memenM && !misaligned && !outOfRange;
    assign enterDone = (goReq && (WAIT_STATES == 0)) || ((state == WAIT) && (waitCnt == 4'd0));

    assign stallM  = rst && (goReq || (state == WAIT));
    assign adelM   = rst && (state == IDLE) && memenM && misaligned && !memwriteM;
    assign adesM   = rst && (state == IDLE) && memenM && misaligned && memwriteM;
    assign buserrM = rst && (state == IDLE) && memenM && !misaligned && outOfRange;

    // Next-state logic
    always_comb begin
        stateNext = state;
        case (state)
            IDLE: if (goReq) stateNext = (WAIT_STATES > 0) ? WAIT : DONE;
            WAIT: if (waitCnt == 4'd0) stateNext = DONE;
            DONE: stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // State register and wait counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            waitCnt <= 4'd0;
        end else begin
            state <= stateNext;
            if (goReq)
                waitCnt <= CNT_INIT;
            else if (state == WAIT && waitCnt != 4'd0)
                waitCnt <= waitCnt - 4'd1;
        end
    end

    // Load lane extraction and extension
    always_comb begin
        selByte = ramWord[7:0];
        case (aluoutM[1:0])
            2'd0: selByte = ramWord[7:0];
            2'd1: selByte = ramWord[15:8];
            2'd2: selByte = ramWord[23:16];
            2'd3: selByte = ramWord[31:24];
            default: selByte = ramWord[7:0];
        endcase
        selHalf = aluoutM[1] ? ramWord[31:16] : ramWord[15:0];
        case (sizeM)
            2'b00:   loadVal = {{24{~unsignedM & selByte[7]}}, selByte};
            2'b01:   loadVal = {{16{~unsignedM & selHalf[15]}}, selHalf};
            default: loadVal = ramWord;
        endcase
    end

    // Store lane enables and replicated data
    always_comb begin
        case (sizeM)
            2'b00: begin
                byteEn    = 4'b0001 << aluoutM[1:0];
                storeData = {4{writedataM[7:0]}};
            end
            2'b01: begin
                byteEn    = aluoutM[1] ? 4'b1100 : 4'b0011;
                storeData = {2{writedataM[15:0]}};
            end
            default: begin
                byteEn    = 4'b1111;
                storeData = writedataM;
            end
        endcase
    end

    // Load result register, updated only when a load completes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            readdataM <= 32'd0;
        else if (enterDone && !memwriteM)
            readdataM <= loadVal;
    end

    // RAM byte-lane writes on completion of a store; contents survive reset
    always_ff @(posedge clk) begin
        if (enterDone && memwriteM) begin
            for (int b = 0; b < 4; b++)
                if (byteEn[b]) mem[wordIdx][8*b +: 8] <= storeData[8*b +: 8];
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (WAIT_STATES=1, ADDR_WIDTH=10).
module tb_dmem_responder;

    localparam int WS = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        memenM, memwriteM, unsignedM;
    logic [1:0]  sizeM;
    logic [31:0] aluoutM, writedataM;
    logic [31:0] readdataM;
    logic        stallM, adelM, adesM, buserrM;

    int nVec = 0;
    int nErr = 0;
    logic [31:0] rd;

    dmem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(WS)) dut (
        .clk(clk), .rst(rst), .memenM(memenM), .memwriteM(memwriteM),
        .sizeM(sizeM), .unsignedM(unsignedM), .aluoutM(aluoutM),
        .writedataM(writedataM), .readdataM(readdataM), .stallM(stallM),
        .adelM(adelM), .adesM(adesM), .buserrM(buserrM)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nVec++;
        if (obs !== exp) begin
            nErr++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    // One aligned access: stall for cycles 0..WS, then a DONE cycle
    task automatic acc(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       output logic [31:0] res);
        @(posedge clk); #1;
        memenM = 1'b1; memwriteM = we; sizeM = sz; unsignedM = uns;
        aluoutM = addr; writedataM = wd;
        for (int c = 0; c <= WS; c++) begin
            @(negedge clk);
            chk("stallBusy", {31'd0, stallM}, 32'd1);
        end
        @(negedge clk);
        chk("stallDone", {31'd0, stallM}, 32'd0);
        res = readdataM;
        @(posedge clk); #1;
        memenM = 1'b0;
    endtask

    initial begin
        rst = 1'b0; memenM = 1'b1; memwriteM = 1'b0; sizeM = 2'b01;
        unsignedM = 1'b0; aluoutM = 32'h31; writedataM = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rstRead",  readdataM, 32'd0);
        chk("rstStall", {31'd0, stallM}, 32'd0);
        chk("rstFlags", {29'd0, adelM, adesM, buserrM}, 32'd0);
        memenM = 1'b0;
        @(posedge clk); #1 rst = 1'b1;

        // Word store/load
        acc(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, rd);
        acc(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd);
        chk("lw10", rd, 32'hDEADBEEF);

        // Byte stores over a zeroed word; upper data bits must be ignored
        acc(1'b1, 2'b10, 1'b0, 32'h20, 32'h0, rd);
        acc(1'b1, 2'b00, 1'b0, 32'h21, 32'hAAAAAA80, rd);
        acc(1'b1, 2'b00, 1'b0, 32'h22, 32'h5555557F, rd);
        acc(1'b0, 2'b00, 1'b0, 32'h21, 32'h0, rd); chk("lb21",  rd, 32'hFFFFFF80);
        acc(1'b0, 2'b00, 1'b1, 32'h21, 32'h0, rd); chk("lbu21", rd, 32'h00000080);
        acc(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, rd); chk("lh22",  rd, 32'h0000007F);
        acc(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd); chk("lw20",  rd, 32'h007F8000);
        acc(1'b0, 2'b01, 1'b0, 32'h20, 32'h0, rd); chk("lh20",  rd, 32'hFFFF8000);
        acc(1'b0, 2'b01, 1'b1, 32'h20, 32'h0, rd); chk("lhu20", rd, 32'h00008000);
        acc(1'b1, 2'b10, 1'b0, 32'h30, 32'h11223344, rd);
        chk("storeHold", readdataM, 32'h00008000);

        // Misaligned load: flag for one cycle, no stall, readdata holds
        @(posedge clk); #1;
        memenM = 1'b1; memwriteM = 1'b0; sizeM = 2'b01; aluoutM = 32'h31;
        @(negedge clk);
        chk("adelLh", {31'd0, adelM}, 32'd1);
        chk("adelStall", {31'd0, stallM}, 32'd0);
        chk("adelAdes", {31'd0, adesM}, 32'd0);
        chk("adelHold", readdataM, 32'h00008000);
        @(posedge clk); #1 memenM = 1'b0;
        @(negedge clk);
        chk("adelClear", {31'd0, adelM}, 32'd0);

        // Misaligned store: flagged, no write
        @(posedge clk); #1;
        memenM = 1'b1; memwriteM = 1'b1; sizeM = 2'b10; aluoutM = 32'h32;
        writedataM = 32'hFFFFFFFF;
        @(negedge clk);
        chk("adesSw", {31'd0, adesM}, 32'd1);
        chk("adesStall", {31'd0, stallM}, 32'd0);
        @(posedge clk); #1 memenM = 1'b0;
        acc(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, rd); chk("lw30", rd, 32'h11223344);

        // Halfword store into upper lane
        acc(1'b1, 2'b01, 1'b0, 32'h32, 32'hCAFEBEEF, rd);
        acc(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, rd); chk("shUpper", rd, 32'hBEEF3344);

        // Reset during WAIT abandons the store
        acc(1'b1, 2'b10, 1'b0, 32'h40, 32'h0BADF00D, rd);
        @(posedge clk); #1;
        memenM = 1'b1; memwriteM = 1'b1; sizeM = 2'b10; aluoutM = 32'h40;
        writedataM = 32'h12345678;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        chk("midWaitStall", {31'd0, stallM}, 32'd1);
        rst = 1'b0;
        #1;
        chk("midRstStall", {31'd0, stallM}, 32'd0);
        chk("midRstRead", readdataM, 32'd0);
        memenM = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        acc(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, rd); chk("lw40", rd, 32'h0BADF00D);

        // Upper address bits: alias by default, bus error when range-checked
        acc(1'b1, 2'b10, 1'b0, 32'h0, 32'h600DCAFE, rd);
`ifdef DMEM_RANGE_CHECK_EN
        @(posedge clk); #1;
        memenM = 1'b1; memwriteM = 1'b0; sizeM = 2'b10; aluoutM = 32'h00001000;
        @(negedge clk);
        chk("busErr", {31'd0, buserrM}, 32'd1);
        chk("busErrStall", {31'd0, stallM}, 32'd0);
        chk("busErrHold", readdataM, 32'h0BADF00D);
        @(posedge clk); #1 memenM = 1'b0;
`else
        acc(1'b0, 2'b10, 1'b0, 32'h00001000, 32'h0, rd);
        chk("alias", rd, 32'h600DCAFE);
        chk("noBusErr", {31'd0, buserrM}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
